btn_debounce_step: RTL and testbench

- Upstream conditioning stage for the 3-bit up-counter.
- Takes a raw asynchronous pushbutton and synchronises it, then debounces it.
- Emits a debounced level, a one-cycle `step` pulse per accepted press (plus optional auto-repeat pulses while held), and a one-cycle release pulse.
- `step` is the counter's single-increment request.

---
 rtl/btn_debounce_step.sv | 130 +++++++++++++
 tb/tb_btn_debounce_step.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_step.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM,
// press/auto-repeat step pulses and a release pulse.
module btn_debounce_step #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic step,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DC_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RC_LAST =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam bit REP_EN = (REPEAT_CYCLES != 0);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_rcnt;
  logic             r_level;
  logic             r_step;
  logic             r_rel;

  state_t           w_state;
  logic [CNT_W-1:0] w_dcnt;
  logic [CNT_W-1:0] w_rcnt;
  logic             w_level;
  logic             w_step;
  logic             w_rel;
  logic             w_sync;

  assign w_sync        = r_s2;
  assign btn_level     = r_level;
  assign step          = r_step;
  assign release_pulse = r_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE;
      r_dcnt  <= '0;
      r_rcnt  <= '0;
      r_level <= 1'b0;
      r_step  <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_s1    <= btn_in;
      r_s2    <= r_s1;
      r_state <= w_state;
      r_dcnt  <= w_dcnt;
      r_rcnt  <= w_rcnt;
      r_level <= w_level;
      r_step  <= w_step;
      r_rel   <= w_rel;
    end
  end

  // Pulses default low so each one lasts exactly one cycle.
  always_comb begin
    w_state = r_state;
    w_dcnt  = r_dcnt;
    w_rcnt  = r_rcnt;
    w_level = r_level;
    w_step  = 1'b0;
    w_rel   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_level = 1'b0;
        if (w_sync) begin
          w_state = PRESS_WAIT;
          w_dcnt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state = IDLE;
        end else if (r_dcnt == DC_LAST) begin
          w_state = PRESSED;
          w_level = 1'b1;
          w_step  = 1'b1;
          w_rcnt  = '0;
        end else begin
          w_dcnt = r_dcnt + ONE;
        end
      end
      PRESSED: begin
        if (!w_sync) begin
          w_state = RELEASE_WAIT;
          w_dcnt  = '0;
        end else if (REP_EN) begin
          if (r_rcnt == RC_LAST) begin
            w_step = 1'b1;
            w_rcnt = '0;
          end else begin
            w_rcnt = r_rcnt + ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (w_sync) begin
          w_state = PRESSED;
          w_rcnt  = '0;
        end else if (r_dcnt == DC_LAST) begin
          w_state = IDLE;
          w_level = 1'b0;
          w_rel   = 1'b1;
        end else begin
          w_dcnt = r_dcnt + ONE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debounce_step.sv
// Directed bench for btn_debounce_step: one instance without
// auto-repeat, one with an 8-cycle repeat period.
module tb_btn_debounce_step;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic lvl0, stp0, rel0;
  logic lvl1, stp1, rel1;

  always #5 clk = ~clk;

  btn_debounce_step #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (0),
    .CNT_W          (8)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (lvl0),
    .step         (stp0),
    .release_pulse(rel0)
  );

  btn_debounce_step #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8),
    .CNT_W          (8)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (lvl1),
    .step         (stp1),
    .release_pulse(rel1)
  );

  int errs   = 0;
  int checks = 0;
  int ec     = 0;
  int ns0, nr0, se0, re0;
  int ns1, se1, fs1;
  logic [2:0] cnt0, cnt1;
  int c;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    ns0 = 0; nr0 = 0; se0 = -1; re0 = -1;
    ns1 = 0; se1 = -1; fs1 = -1;
  endtask

  // Advance one edge, sample 1 ns later, and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
    chk("excl0", {31'd0, stp0 & rel0}, 32'd0);
    chk("excl1", {31'd0, stp1 & rel1}, 32'd0);
    if (stp0) begin
      ns0++; se0 = ec; cnt0 = cnt0 + 3'd1;
    end
    if (rel0) begin
      nr0++; re0 = ec;
    end
    if (stp1) begin
      if (ns1 == 0) fs1 = ec;
      ns1++; se1 = ec; cnt1 = cnt1 + 3'd1;
    end
  endtask

  initial begin
    cnt0 = '0;
    cnt1 = '0;
    clr();
    rst    = 1'b1;
    btn_in = 1'b1;
    tick();
    tick();
    chk("rst_lvl",  {31'd0, lvl0}, 32'd0);
    chk("rst_step", {31'd0, stp0}, 32'd0);
    chk("rst_rel",  {31'd0, rel0}, 32'd0);
    chk("rst_lvl1", {31'd0, lvl1}, 32'd0);

    // held through reset: accepted at edge 7 after deassert
    rst = 1'b0;
    clr();
    c = ec;
    repeat (6) tick();
    chk("por_early", {31'd0, lvl0}, 32'd0);
    tick();
    chk("por_lvl",  {31'd0, lvl0}, 32'd1);
    chk("por_step", {31'd0, stp0}, 32'd1);
    tick();
    chk("por_1cyc", {31'd0, stp0}, 32'd0);
    chk("por_edge", se0, c + 7);
    btn_in = 1'b0;
    repeat (12) tick();
    chk("por_off", {31'd0, lvl0}, 32'd0);

    // clean press and release
    clr();
    cnt0 = '0;
    btn_in = 1'b1;
    c = ec;
    repeat (20) tick();
    chk("cln_lvl",   {31'd0, lvl0}, 32'd1);
    chk("cln_nstep", ns0, 1);
    chk("cln_sedge", se0, c + 7);
    btn_in = 1'b0;
    c = ec;
    repeat (10) tick();
    chk("cln_nrel",  nr0, 1);
    chk("cln_redge", re0, c + 7);
    chk("cln_off",   {31'd0, lvl0}, 32'd0);
    chk("cln_cnt",   {29'd0, cnt0}, 32'd1);
    chk("cln_nstep2", ns0, 1);

    // press bounce: 2-cycle high segments
    clr();
    repeat (2) begin
      btn_in = 1'b1;
      tick(); tick();
      btn_in = 1'b0;
      tick(); tick();
    end
    chk("bnc_nstep", ns0, 0);
    chk("bnc_lvl",   {31'd0, lvl0}, 32'd0);
    btn_in = 1'b1;
    c = ec;
    repeat (6) tick();
    chk("bnc_early", ns0, 0);
    tick();
    chk("bnc_step",  {31'd0, stp0}, 32'd1);
    chk("bnc_sedge", se0, c + 7);
    repeat (4) tick();

    // 1-cycle release glitches while held
    clr();
    repeat (3) begin
      btn_in = 1'b0;
      tick();
      btn_in = 1'b1;
      repeat (5) tick();
    end
    repeat (5) tick();
    chk("gl_lvl",   {31'd0, lvl0}, 32'd1);
    chk("gl_nrel",  nr0, 0);
    chk("gl_nstep", ns0, 0);
    btn_in = 1'b0;
    c = ec;
    repeat (10) tick();
    chk("gl_nrel2", nr0, 1);
    chk("gl_redge", re0, c + 7);

    // auto-repeat on the second instance
    clr();
    cnt1 = '0;
    btn_in = 1'b1;
    c = ec;
    repeat (40) tick();
    chk("rep_n5",    ns1, 5);
    chk("rep_first", fs1, c + 7);
    chk("rep_last",  se1, c + 39);
    chk("rep_norep", ns0, 1);
    repeat (24) tick();
    chk("rep_n8",    ns1, 8);
    chk("rep_last8", se1, c + 63);
    chk("rep_wrap",  {29'd0, cnt1}, 32'd0);
    btn_in = 1'b0;
    repeat (12) tick();
    chk("rep_off",   {31'd0, lvl1}, 32'd0);

    // reset during PRESS_WAIT
    btn_in = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rpw_lvl",  {31'd0, lvl0}, 32'd0);
    chk("rpw_step", {31'd0, stp0}, 32'd0);
    chk("rpw_rel",  {31'd0, rel0}, 32'd0);
    rst = 1'b0;
    clr();
    c = ec;
    repeat (6) tick();
    chk("rpw_early", {31'd0, lvl0}, 32'd0);
    tick();
    chk("rpw_lvl2",  {31'd0, lvl0}, 32'd1);
    chk("rpw_step2", {31'd0, stp0}, 32'd1);
    chk("rpw_sedge", se0, c + 7);

    // reset during PRESSED
    repeat (3) tick();
    clr();
    rst = 1'b1;
    tick();
    chk("rpr_lvl",  {31'd0, lvl0}, 32'd0);
    chk("rpr_step", {31'd0, stp0}, 32'd0);
    chk("rpr_rel",  {31'd0, rel0}, 32'd0);
    chk("rpr_lvl1", {31'd0, lvl1}, 32'd0);
    rst = 1'b0;
    c = ec;
    repeat (6) tick();
    chk("rpr_early", {31'd0, lvl0}, 32'd0);
    tick();
    chk("rpr_lvl2",  {31'd0, lvl0}, 32'd1);
    chk("rpr_sedge", se0, c + 7);
    chk("rpr_nrel",  nr0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
